// File: rtl/clock_ctrl_pkg.sv
// Shared types and limits for the alarm-clock UI controller.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        E_TH = 3'd1,
        E_TM = 3'd2,
        E_AH = 3'd3,
        E_AM = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    localparam logic [1:0] FLD_TIME_H  = 2'd0;
    localparam logic [1:0] FLD_TIME_M  = 2'd1;
    localparam logic [1:0] FLD_ALARM_H = 2'd2;
    localparam logic [1:0] FLD_ALARM_M = 2'd3;

    localparam int unsigned HOUR_MAX    = 23;
    localparam int unsigned MIN_MAX     = 59;
    localparam int unsigned MIN_PER_DAY = (HOUR_MAX + 1) * (MIN_MAX + 1);

endpackage

// File: rtl/bcd_time_add_min.sv
// Combinational BCD HH:MM + k minutes, wrapping at 24 h.
module bcd_time_add_min
    import clock_ctrl_pkg::*;
(
    input  bcd_time_t  i_time,
    input  logic [5:0] i_k,
    output bcd_time_t  o_time
);

    localparam logic [10:0] MPH = 11'(MIN_MAX + 1);
    localparam logic [10:0] MPD = 11'(MIN_PER_DAY);

    logic [10:0] w_sum;
    logic [10:0] w_wrap;
    logic [10:0] w_hrs;
    logic [10:0] w_min;

    // k < 64 keeps the sum below two days, so a single subtraction wraps it
    assign w_sum  = (11'(i_time.h1) * 11'd10 + 11'(i_time.h0)) * MPH
                  + 11'(i_time.m1) * 11'd10 + 11'(i_time.m0) + 11'(i_k);
    assign w_wrap = (w_sum >= MPD) ? (w_sum - MPD) : w_sum;
    assign w_hrs  = w_wrap / MPH;
    assign w_min  = w_wrap % MPH;

    assign o_time = '{h1: 2'(w_hrs / 11'd10), h0: 4'(w_hrs % 11'd10),
                      m1: 3'(w_min / 11'd10), m0: 4'(w_min % 11'd10)};

endmodule

// File: rtl/clock_ctrl_fsm.sv
// Alarm-clock UI controller: button pulses -> core load/stop strobes,
// time/alarm editing with idle timeout, stop and snooze handling.
module clock_ctrl_fsm
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    input  logic       alarm_in,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [2:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] ld_h1,
    output logic [3:0] ld_h0,
    output logic [2:0] ld_m1,
    output logic [3:0] ld_m0,
    output logic       ld_time,
    output logic       ld_alarm,
    output logic       al_on,
    output logic       stop_al,
    output logic       edit_active,
    output logic [1:0] edit_field,
    output logic       snoozed
);

    localparam int unsigned   CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t    r_state,  w_state_nxt;
    bcd_time_t r_edit,   w_edit_nxt;
    bcd_time_t r_usr,    w_usr_nxt;
    bcd_time_t r_prog,   w_prog_nxt;
    bcd_time_t r_ld_bus, w_ld_bus_nxt;
    logic      r_alarm_en, w_alarm_en_nxt;
    logic      r_mute,     w_mute_nxt;
    logic      r_snoozed,  w_snoozed_nxt;
    logic      r_ld_time,  w_ld_time_nxt;
    logic      r_ld_alarm, w_ld_alarm_nxt;
    logic      r_stop_al,  w_stop_al_nxt;
    logic [CW-1:0] r_tcnt, w_tcnt_nxt;

    bcd_time_t  w_cur;
    bcd_time_t  w_snz_time;
    bcd_time_t  w_inc_res;
    bcd_time_t  w_inc_time;
    logic       w_any_btn;
    logic       w_edit_hours;
    logic [5:0] w_inc_k;

    assign w_cur        = '{h1: cur_h1, h0: cur_h0, m1: cur_m1, m0: cur_m0};
    assign w_any_btn    = btn_stop | btn_snooze | btn_set | btn_mode | btn_inc;
    assign w_edit_hours = (r_state == E_TH) || (r_state == E_AH);
    // +60 min on an HH:MM value steps the hour with 23->00 wrap
    assign w_inc_k      = w_edit_hours ? 6'd60 : 6'd1;

    bcd_time_add_min u_snooze_add (
        .i_time (w_cur),
        .i_k    (6'(SNOOZE_MIN)),
        .o_time (w_snz_time)
    );

    bcd_time_add_min u_inc_add (
        .i_time (r_edit),
        .i_k    (w_inc_k),
        .o_time (w_inc_res)
    );

    always_comb begin
        w_inc_time = r_edit;
        if (w_edit_hours) begin
            w_inc_time.h1 = w_inc_res.h1;
            w_inc_time.h0 = w_inc_res.h0;
        end else begin
            w_inc_time.m1 = w_inc_res.m1;
            w_inc_time.m0 = w_inc_res.m0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_edit_nxt     = r_edit;
        w_usr_nxt      = r_usr;
        w_prog_nxt     = r_prog;
        w_ld_bus_nxt   = r_ld_bus;
        w_alarm_en_nxt = r_alarm_en;
        w_mute_nxt     = r_mute & (w_cur == r_prog);
        w_snoozed_nxt  = r_snoozed;
        w_ld_time_nxt  = 1'b0;
        w_ld_alarm_nxt = 1'b0;
        w_stop_al_nxt  = 1'b0;
        w_tcnt_nxt     = '0;

        if (btn_stop) begin
            if (alarm_in) begin
                w_stop_al_nxt = 1'b1;
                w_mute_nxt    = 1'b1;
                if (r_snoozed) begin
                    w_ld_alarm_nxt = 1'b1;
                    w_ld_bus_nxt   = r_usr;
                    w_prog_nxt     = r_usr;
                    w_snoozed_nxt  = 1'b0;
                end
            end
        end else if (btn_snooze) begin
            if (alarm_in) begin
                w_stop_al_nxt  = 1'b1;
                w_mute_nxt     = 1'b1;
                w_ld_alarm_nxt = 1'b1;
                w_ld_bus_nxt   = w_snz_time;
                w_prog_nxt     = w_snz_time;
                w_snoozed_nxt  = 1'b1;
            end else if (r_state == RUN) begin
                w_alarm_en_nxt = ~r_alarm_en;
            end
        end else if (btn_set) begin
            case (r_state)
                E_TH, E_TM: begin
                    w_ld_time_nxt = 1'b1;
                    w_ld_bus_nxt  = r_edit;
                    w_state_nxt   = RUN;
                end
                E_AH, E_AM: begin
                    w_ld_alarm_nxt = 1'b1;
                    w_ld_bus_nxt   = r_edit;
                    w_usr_nxt      = r_edit;
                    w_prog_nxt     = r_edit;
                    w_snoozed_nxt  = 1'b0;
                    w_state_nxt    = RUN;
                end
                default: ;
            endcase
        end else if (btn_mode) begin
            case (r_state)
                RUN: begin
                    w_state_nxt = E_TH;
                    w_edit_nxt  = w_cur;
                end
                E_TH: w_state_nxt = E_TM;
                E_TM: begin
                    w_state_nxt = E_AH;
                    w_edit_nxt  = r_usr;
                end
                E_AH:    w_state_nxt = E_AM;
                default: w_state_nxt = RUN;
            endcase
        end else if (btn_inc) begin
            if (r_state != RUN) w_edit_nxt = w_inc_time;
        end

        if ((r_state != RUN) && !w_any_btn) begin
            if (r_tcnt == TO_LAST) w_state_nxt = RUN;
            else                   w_tcnt_nxt  = r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_edit     <= '0;
            r_usr      <= '0;
            r_prog     <= '0;
            r_ld_bus   <= '0;
            r_alarm_en <= 1'b0;
            r_mute     <= 1'b0;
            r_snoozed  <= 1'b0;
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
            r_stop_al  <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_edit     <= w_edit_nxt;
            r_usr      <= w_usr_nxt;
            r_prog     <= w_prog_nxt;
            r_ld_bus   <= w_ld_bus_nxt;
            r_alarm_en <= w_alarm_en_nxt;
            r_mute     <= w_mute_nxt;
            r_snoozed  <= w_snoozed_nxt;
            r_ld_time  <= w_ld_time_nxt;
            r_ld_alarm <= w_ld_alarm_nxt;
            r_stop_al  <= w_stop_al_nxt;
            r_tcnt     <= w_tcnt_nxt;
        end
    end

    always_comb begin
        case (r_state)
            E_TM:    edit_field = FLD_TIME_M;
            E_AH:    edit_field = FLD_ALARM_H;
            E_AM:    edit_field = FLD_ALARM_M;
            default: edit_field = FLD_TIME_H;
        endcase
    end

    assign ld_h1       = r_ld_bus.h1;
    assign ld_h0       = r_ld_bus.h0;
    assign ld_m1       = r_ld_bus.m1;
    assign ld_m0       = r_ld_bus.m0;
    assign ld_time     = r_ld_time;
    assign ld_alarm    = r_ld_alarm;
    assign stop_al     = r_stop_al;
    assign snoozed     = r_snoozed;
    assign al_on       = r_alarm_en & ~r_mute;
    assign edit_active = (r_state != RUN);

endmodule

// File: tb/tb_clock_ctrl_fsm.sv
// Self-checking bench for clock_ctrl_fsm: directed tables, corner sequences,
// and random traffic against a minute-of-day reference model.
module tb_clock_ctrl_fsm;

    localparam int SNZ = 5;
    localparam int TO  = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_set, btn_stop, btn_snooze;
    logic       alarm_in;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [2:0] cur_m1;
    logic [3:0] cur_m0;
    logic [1:0] ld_h1;
    logic [3:0] ld_h0;
    logic [2:0] ld_m1;
    logic [3:0] ld_m0;
    logic       ld_time, ld_alarm, al_on, stop_al, edit_active, snoozed;
    logic [1:0] edit_field;

    always #5 clk = ~clk;

    clock_ctrl_fsm #(.SNOOZE_MIN(SNZ), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_set(btn_set),
        .btn_stop(btn_stop), .btn_snooze(btn_snooze), .alarm_in(alarm_in),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0),
        .ld_time(ld_time), .ld_alarm(ld_alarm), .al_on(al_on), .stop_al(stop_al),
        .edit_active(edit_active), .edit_field(edit_field), .snoozed(snoozed)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cur_min  = 0;

    // Reference model: times as minute-of-day, mode 0 = run, 1..4 = edit fields
    int m_mode, m_eh, m_em, m_usr, m_prog, m_en, m_mute, m_snz, m_cnt;
    int m_ldt, m_lda, m_stop, m_bus;

    typedef struct {
        logic [4:0] btn;  // {stop, snooze, set, mode, inc}
        int ldt;
        int lda;
        int bus;          // minute-of-day, -1 = not checked
        int ea;
        int fld;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_bus();
        return (int'(ld_h1) * 10 + int'(ld_h0)) * 60 + int'(ld_m1) * 10 + int'(ld_m0);
    endfunction

    task automatic set_cur(input int t);
        cur_min = t;
        cur_h1  = 2'((t / 60) / 10);
        cur_h0  = 4'((t / 60) % 10);
        cur_m1  = 3'((t % 60) / 10);
        cur_m0  = 4'(t % 10);
    endtask

    task automatic set_btn(input logic [4:0] b);
        {btn_stop, btn_snooze, btn_set, btn_mode, btn_inc} = b;
    endtask

    task automatic model_reset();
        m_mode = 0; m_eh = 0; m_em = 0; m_usr = 0; m_prog = 0;
        m_en = 0; m_mute = 0; m_snz = 0; m_cnt = 0;
        m_ldt = 0; m_lda = 0; m_stop = 0; m_bus = 0;
    endtask

    task automatic model_step();
        int pre_mode;
        bit any;
        pre_mode = m_mode;
        any = btn_stop | btn_snooze | btn_set | btn_mode | btn_inc;
        m_ldt = 0; m_lda = 0; m_stop = 0;
        if (m_mute != 0 && cur_min != m_prog) m_mute = 0;
        if (btn_stop) begin
            if (alarm_in) begin
                m_stop = 1; m_mute = 1;
                if (m_snz != 0) begin
                    m_lda = 1; m_bus = m_usr; m_prog = m_usr; m_snz = 0;
                end
            end
        end else if (btn_snooze) begin
            if (alarm_in) begin
                m_stop = 1; m_mute = 1; m_lda = 1;
                m_bus = (cur_min + SNZ) % 1440; m_prog = m_bus; m_snz = 1;
            end else if (m_mode == 0) begin
                m_en = (m_en == 0) ? 1 : 0;
            end
        end else if (btn_set) begin
            if (m_mode == 1 || m_mode == 2) begin
                m_ldt = 1; m_bus = m_eh * 60 + m_em; m_mode = 0;
            end else if (m_mode >= 3) begin
                m_lda = 1; m_bus = m_eh * 60 + m_em;
                m_usr = m_bus; m_prog = m_bus; m_snz = 0; m_mode = 0;
            end
        end else if (btn_mode) begin
            if (m_mode == 0) begin
                m_eh = cur_min / 60; m_em = cur_min % 60;
            end else if (m_mode == 2) begin
                m_eh = m_usr / 60; m_em = m_usr % 60;
            end
            m_mode = (m_mode + 1) % 5;
        end else if (btn_inc) begin
            if (m_mode == 1 || m_mode == 3) m_eh = (m_eh + 1) % 24;
            else if (m_mode != 0)           m_em = (m_em + 1) % 60;
        end
        if (pre_mode == 0 || any) m_cnt = 0;
        else if (m_cnt == TO - 1) begin
            m_mode = 0; m_cnt = 0;
        end else m_cnt++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ld_time"},  int'(ld_time),     m_ldt);
        chk({tag, "_ld_alarm"}, int'(ld_alarm),    m_lda);
        chk({tag, "_stop_al"},  int'(stop_al),     m_stop);
        chk({tag, "_al_on"},    int'(al_on),       (m_en != 0 && m_mute == 0) ? 1 : 0);
        chk({tag, "_edit_act"}, int'(edit_active), (m_mode != 0) ? 1 : 0);
        chk({tag, "_field"},    int'(edit_field),  (m_mode == 0) ? 0 : m_mode - 1);
        chk({tag, "_snoozed"},  int'(snoozed),     m_snz);
        chk({tag, "_bus"},      dut_bus(),         m_bus);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        set_btn(5'b0);
    endtask

    task automatic press(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            set_btn(b);
            tick();
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        set_btn(v.btn);
        tick();
        chk({tag, "_ld_time"},  int'(ld_time),     v.ldt);
        chk({tag, "_ld_alarm"}, int'(ld_alarm),    v.lda);
        chk({tag, "_edit_act"}, int'(edit_active), v.ea);
        chk({tag, "_field"},    int'(edit_field),  v.fld);
        if (v.bus >= 0) chk({tag, "_bus"}, dut_bus(), v.bus);
    endtask

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_INC  = 5'b00001;
    localparam logic [4:0] B_MODE = 5'b00010;
    localparam logic [4:0] B_SET  = 5'b00100;
    localparam logic [4:0] B_SNZ  = 5'b01000;
    localparam logic [4:0] B_STOP = 5'b10000;

    initial begin
        logic [4:0] rb;
        int r;

        reset = 1'b1;
        set_btn(5'b0);
        alarm_in = 1'b0;
        set_cur(0);
        model_reset();

        // edit/commit 03:02, then alarm-field wrap from 23:59
        tbl_a.push_back(vec_t'{B_MODE, 0, 0, -1, 1, 0});
        tbl_a.push_back(vec_t'{B_INC,  0, 0, -1, 1, 0});
        tbl_a.push_back(vec_t'{B_INC,  0, 0, -1, 1, 0});
        tbl_a.push_back(vec_t'{B_INC,  0, 0, -1, 1, 0});
        tbl_a.push_back(vec_t'{B_MODE, 0, 0, -1, 1, 1});
        tbl_a.push_back(vec_t'{B_INC,  0, 0, -1, 1, 1});
        tbl_a.push_back(vec_t'{B_INC,  0, 0, -1, 1, 1});
        tbl_a.push_back(vec_t'{B_SET,  1, 0, 182, 0, 0});
        tbl_a.push_back(vec_t'{B_NONE, 0, 0, 182, 0, 0});

        tbl_b.push_back(vec_t'{B_MODE, 0, 0, -1, 1, 0});
        tbl_b.push_back(vec_t'{B_MODE, 0, 0, -1, 1, 1});
        tbl_b.push_back(vec_t'{B_MODE, 0, 0, -1, 1, 2});
        tbl_b.push_back(vec_t'{B_INC,  0, 0, -1, 1, 2});
        tbl_b.push_back(vec_t'{B_MODE, 0, 0, -1, 1, 3});
        tbl_b.push_back(vec_t'{B_INC,  0, 0, -1, 1, 3});
        tbl_b.push_back(vec_t'{B_SET,  0, 1, 0, 0, 0});
        tbl_b.push_back(vec_t'{B_NONE, 0, 0, 0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_time", int'(ld_time), 0);
        chk("rst_ld_alarm", int'(ld_alarm), 0);
        chk("rst_stop_al", int'(stop_al), 0);
        chk("rst_al_on", int'(al_on), 0);
        chk("rst_edit_act", int'(edit_active), 0);
        chk("rst_field", int'(edit_field), 0);
        chk("rst_snoozed", int'(snoozed), 0);
        chk("rst_bus", dut_bus(), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        foreach (tbl_a[i]) apply_vec(tbl_a[i], $sformatf("tblA%0d", i));

        // program user alarm 23:59 by hand
        press(B_MODE, 3);
        chk("al_build_field", int'(edit_field), 2);
        press(B_INC, 23);
        press(B_MODE, 1);
        press(B_INC, 59);
        press(B_SET, 1);
        chk("al_build_ld_alarm", int'(ld_alarm), 1);
        chk("al_build_bus", dut_bus(), 23 * 60 + 59);

        foreach (tbl_b[i]) apply_vec(tbl_b[i], $sformatf("tblB%0d", i));

        // idle timeout: exactly TO idle cycles, and a button restarts the count
        press(B_MODE, 1);
        press(B_NONE, TO - 1);
        chk("to_before_edge", int'(edit_active), 1);
        tick();
        chk("to_fired", int'(edit_active), 0);
        chk("to_no_load", int'(ld_time), 0);
        press(B_MODE, 1);
        press(B_NONE, TO - 1);
        press(B_INC, 1);
        chk("to_inc_keeps", int'(edit_active), 1);
        press(B_NONE, TO - 1);
        chk("to_restart_hold", int'(edit_active), 1);
        tick();
        chk("to_restart_fire", int'(edit_active), 0);

        // snooze across midnight
        set_cur(23 * 60 + 58);
        press(B_SNZ, 1);
        chk("en_toggle_al_on", int'(al_on), 1);
        alarm_in = 1'b1;
        press(B_SNZ, 1);
        alarm_in = 1'b0;
        chk("snz_stop_al", int'(stop_al), 1);
        chk("snz_al_on", int'(al_on), 0);
        chk("snz_ld_alarm", int'(ld_alarm), 1);
        chk("snz_bus", dut_bus(), 3);
        chk("snz_snoozed", int'(snoozed), 1);
        tick();
        chk("snz_stop_pulse", int'(stop_al), 0);
        chk("snz_al_on_back", int'(al_on), 1);

        // snooze alarm fires, stop restores user alarm 00:00
        set_cur(3);
        alarm_in = 1'b1;
        press(B_STOP, 1);
        alarm_in = 1'b0;
        chk("stp_stop_al", int'(stop_al), 1);
        chk("stp_ld_alarm", int'(ld_alarm), 1);
        chk("stp_bus", dut_bus(), 0);
        chk("stp_snoozed", int'(snoozed), 0);
        chk("stp_al_on", int'(al_on), 0);
        tick();

        // plain stop within the matching minute holds mute until the minute moves
        set_cur(0);
        alarm_in = 1'b1;
        press(B_STOP, 1);
        alarm_in = 1'b0;
        chk("pstp_stop_al", int'(stop_al), 1);
        chk("pstp_no_ld", int'(ld_alarm), 0);
        press(B_NONE, 3);
        chk("pstp_muted", int'(al_on), 0);
        set_cur(1);
        tick();
        chk("pstp_unmute", int'(al_on), 1);

        // priority: stop beats set and mode
        alarm_in = 1'b1;
        press(B_STOP | B_SET | B_MODE, 1);
        alarm_in = 1'b0;
        chk("pri_stop_al", int'(stop_al), 1);
        chk("pri_no_edit", int'(edit_active), 0);
        chk("pri_no_ld", int'(ld_time), 0);

        // async reset from E_AM with snoozed set
        press(B_MODE, 4);
        chk("ram_field", int'(edit_field), 3);
        alarm_in = 1'b1;
        press(B_SNZ, 1);
        alarm_in = 1'b0;
        chk("ram_snoozed", int'(snoozed), 1);
        chk("ram_field_kept", int'(edit_field), 3);
        tick();
        chk("ram_al_on", int'(al_on), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_edit_act", int'(edit_active), 0);
        chk("arst_field", int'(edit_field), 0);
        chk("arst_al_on", int'(al_on), 0);
        chk("arst_snoozed", int'(snoozed), 0);
        chk("arst_strobes", int'({ld_time, ld_alarm, stop_al}), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // random traffic: dense buttons, then sparse so timeouts occur
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = int'($urandom_range(0, 99));
            if (cyc < 1500) begin
                if (r < 5)       rb = 5'($urandom);
                else if (r < 12) rb = B_STOP;
                else if (r < 22) rb = B_SNZ;
                else if (r < 32) rb = B_SET;
                else if (r < 46) rb = B_MODE;
                else if (r < 66) rb = B_INC;
                else             rb = B_NONE;
            end else begin
                rb = (r < 4) ? 5'(1 << $urandom_range(0, 4)) : B_NONE;
            end
            set_btn(rb);
            alarm_in = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 10)      set_cur((cur_min + 1) % 1440);
            else if (r < 14) set_cur(m_prog);
            else if (r < 16) set_cur(int'($urandom_range(0, 1439)));
            tick();
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
